// File: rtl/reg_operand_fetch_pkg.sv
// Shared constants and FSM state type for the register operand-fetch stage.
package reg_operand_fetch_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 5;
  localparam int RETRY_W_DEF = 8;
  localparam int NUM_SRC     = 4;
  localparam int NUM_DST     = 2;

  // Reset is asynchronous and asserted low.
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_e;

endpackage

// File: rtl/reg_operand_fetch_if.sv
// Instruction, register-file read and operand channels of the fetch stage.
interface reg_operand_fetch_if
  import reg_operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [ADDR_W-1:0] instr_src_1_i, instr_src_2_i, instr_src_3_i, instr_src_4_i;
  logic [ADDR_W-1:0] instr_dst_1_i, instr_dst_2_i;

  logic [ADDR_W-1:0] r_reg_addr_1_o, r_reg_addr_2_o, r_reg_addr_3_o, r_reg_addr_4_o;
  logic [DATA_W-1:0] r_reg_data_1_i, r_reg_data_2_i, r_reg_data_3_i, r_reg_data_4_i;

  logic              op_valid_o;
  logic              op_ready_i;
  logic [DATA_W-1:0] op_data_1_o, op_data_2_o, op_data_3_o, op_data_4_o;
  logic [ADDR_W-1:0] op_dst_1_o, op_dst_2_o;

  // Fetch-stage view.
  modport master (
    input  instr_valid_i, instr_src_1_i, instr_src_2_i, instr_src_3_i, instr_src_4_i,
           instr_dst_1_i, instr_dst_2_i,
    output instr_ready_o,
    output r_reg_addr_1_o, r_reg_addr_2_o, r_reg_addr_3_o, r_reg_addr_4_o,
    input  r_reg_data_1_i, r_reg_data_2_i, r_reg_data_3_i, r_reg_data_4_i,
    output op_valid_o, op_data_1_o, op_data_2_o, op_data_3_o, op_data_4_o,
           op_dst_1_o, op_dst_2_o,
    input  op_ready_i
  );

  // Decoder / register file / execute view.
  modport slave (
    output instr_valid_i, instr_src_1_i, instr_src_2_i, instr_src_3_i, instr_src_4_i,
           instr_dst_1_i, instr_dst_2_i,
    input  instr_ready_o,
    input  r_reg_addr_1_o, r_reg_addr_2_o, r_reg_addr_3_o, r_reg_addr_4_o,
    output r_reg_data_1_i, r_reg_data_2_i, r_reg_data_3_i, r_reg_data_4_i,
    input  op_valid_o, op_data_1_o, op_data_2_o, op_data_3_o, op_data_4_o,
           op_dst_1_o, op_dst_2_o,
    output op_ready_i
  );

endinterface

// File: rtl/reg_operand_fetch.sv
// Operand-fetch stage: latches source addresses, rides out the register file's
// read latency and write-cycle zeroing, then offers four operands downstream.
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RETRY_W = RETRY_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               wb_en_i,
  output logic [RETRY_W-1:0] retry_cnt_o,
  reg_operand_fetch_if.master bus
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  src_q     [NUM_SRC];
  logic [ADDR_W-1:0]  dst_q     [NUM_DST];
  logic [DATA_W-1:0]  rd_data   [NUM_SRC];
  logic [DATA_W-1:0]  op_data_q [NUM_SRC];
  logic [ADDR_W-1:0]  op_dst_q  [NUM_DST];
  logic [RETRY_W-1:0] retry_q;
  logic               accept, read_lost, capture;

  assign rd_data[0] = bus.r_reg_data_1_i;
  assign rd_data[1] = bus.r_reg_data_2_i;
  assign rd_data[2] = bus.r_reg_data_3_i;
  assign rd_data[3] = bus.r_reg_data_4_i;

  // Flush overrides every other event in the cycle it is raised.
  assign accept    = (state_q == S_IDLE) && bus.instr_valid_i && !flush_i;
  assign read_lost = (state_q == S_READ) && wb_en_i && !flush_i;
  assign capture   = (state_q == S_WAIT) && !flush_i;

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RST_ACTIVE) state_q <= S_IDLE;
    else                     state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.instr_valid_i) state_d = S_READ;
        S_READ:  if (!wb_en_i)          state_d = S_WAIT;
        S_WAIT:                         state_d = S_VALID;
        S_VALID: if (bus.op_ready_i)    state_d = S_IDLE;
        default:                        state_d = S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready_o = (state_q == S_IDLE);
  assign bus.op_valid_o    = (state_q == S_VALID);

  // NOTE: these small arrays are individual flops, not RAM macros, so they are
  // all reset explicitly to give a defined output state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RST_ACTIVE) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_q[i]     <= '0;
        op_data_q[i] <= '0;
      end
      for (int j = 0; j < NUM_DST; j++) begin
        dst_q[j]    <= '0;
        op_dst_q[j] <= '0;
      end
      retry_q <= '0;
    end else begin
      if (accept) begin
        src_q[0] <= bus.instr_src_1_i;
        src_q[1] <= bus.instr_src_2_i;
        src_q[2] <= bus.instr_src_3_i;
        src_q[3] <= bus.instr_src_4_i;
        dst_q[0] <= bus.instr_dst_1_i;
        dst_q[1] <= bus.instr_dst_2_i;
      end
      // The file's outputs in WAIT reflect the last clean READ edge.
      if (capture) begin
        for (int i = 0; i < NUM_SRC; i++) op_data_q[i] <= rd_data[i];
        for (int j = 0; j < NUM_DST; j++) op_dst_q[j]  <= dst_q[j];
      end
      if (read_lost && (retry_q != '1)) retry_q <= retry_q + 1'b1;
    end
  end

  assign bus.r_reg_addr_1_o = src_q[0];
  assign bus.r_reg_addr_2_o = src_q[1];
  assign bus.r_reg_addr_3_o = src_q[2];
  assign bus.r_reg_addr_4_o = src_q[3];
  assign bus.op_data_1_o    = op_data_q[0];
  assign bus.op_data_2_o    = op_data_q[1];
  assign bus.op_data_3_o    = op_data_q[2];
  assign bus.op_data_4_o    = op_data_q[3];
  assign bus.op_dst_1_o     = op_dst_q[0];
  assign bus.op_dst_2_o     = op_dst_q[1];
  assign retry_cnt_o        = retry_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Self-checking bench: behavioural 32x8 register file plus a transaction-level
// expectation of operands, latency, retry count and handshakes.
module tb_reg_operand_fetch;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic       wb_en;
  logic [4:0] wr_a1, wr_a2;
  logic [7:0] wr_d1, wr_d2;
  logic [7:0] retry_cnt;

  always #5 clk_i = ~clk_i;

  reg_operand_fetch_if bus ();

  reg_operand_fetch dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .wb_en_i     (wb_en),
    .retry_cnt_o (retry_cnt),
    .bus         (bus.master)
  );

  // Register file: dual write, registered quad read, reads zeroed on write cycles.
  logic [7:0] rf_mem [32];
  logic [7:0] rf_rd  [4];
  always @(posedge clk_i) begin
    if (wb_en) begin
      rf_mem[wr_a1] <= wr_d1;
      rf_mem[wr_a2] <= wr_d2;
      for (int i = 0; i < 4; i++) rf_rd[i] <= '0;
    end else begin
      rf_rd[0] <= rf_mem[bus.r_reg_addr_1_o];
      rf_rd[1] <= rf_mem[bus.r_reg_addr_2_o];
      rf_rd[2] <= rf_mem[bus.r_reg_addr_3_o];
      rf_rd[3] <= rf_mem[bus.r_reg_addr_4_o];
    end
  end
  assign bus.r_reg_data_1_i = rf_rd[0];
  assign bus.r_reg_data_2_i = rf_rd[1];
  assign bus.r_reg_data_3_i = rf_rd[2];
  assign bus.r_reg_data_4_i = rf_rd[3];

  int hs_cnt = 0;
  always @(posedge clk_i) if (bus.op_valid_o && bus.op_ready_i) hs_cnt <= hs_cnt + 1;

  // Reference state, kept by the stimulus side.
  logic [7:0]      ref_mem [32];
  int              exp_retry;
  logic [3:0][4:0] last_src;
  logic [3:0][7:0] last_data;
  logic [1:0][4:0] last_dst;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_wb(input bit en);
    wb_en = en;
    if (en) begin
      wr_a1 = 5'($urandom_range(0, 31));
      wr_a2 = wr_a1 + 5'($urandom_range(1, 31));
      wr_d1 = 8'($urandom_range(1, 255));
      wr_d2 = 8'($urandom_range(1, 255));
      ref_mem[wr_a1] = wr_d1;
      ref_mem[wr_a2] = wr_d2;
    end
  endtask

  task automatic check_bundle(input string tag, input logic [3:0][7:0] d, input logic [1:0][4:0] t);
    check({tag, "_d1"}, bus.op_data_1_o, d[0]);
    check({tag, "_d2"}, bus.op_data_2_o, d[1]);
    check({tag, "_d3"}, bus.op_data_3_o, d[2]);
    check({tag, "_d4"}, bus.op_data_4_o, d[3]);
    check({tag, "_t1"}, bus.op_dst_1_o, t[0]);
    check({tag, "_t2"}, bus.op_dst_2_o, t[1]);
  endtask

  task automatic check_addrs(input string tag, input logic [3:0][4:0] s);
    check({tag, "_a1"}, bus.r_reg_addr_1_o, s[0]);
    check({tag, "_a2"}, bus.r_reg_addr_2_o, s[1]);
    check({tag, "_a3"}, bus.r_reg_addr_3_o, s[2]);
    check({tag, "_a4"}, bus.r_reg_addr_4_o, s[3]);
  endtask

  task automatic clear_ref();
    exp_retry = 0;
    last_src  = '0;
    last_data = '0;
    last_dst  = '0;
  endtask

  // mode: 0 normal, 1 flush in WAIT, 2 flush with op_ready in VALID, 3 async reset in VALID
  task automatic do_txn(input logic [3:0][4:0] s, input logic [1:0][4:0] t,
                        input int n_coll, input int stall, input int mode,
                        input bit acc_wr, input logic [4:0] acc_wa, input logic [7:0] acc_wd);
    logic [3:0][7:0] exp_d;
    int hs_before;
    check("idle_ready", bus.instr_ready_o, 1'b1);
    check_addrs("addr_hold", last_src);
    bus.instr_valid_i = 1'b1;
    {bus.instr_src_4_i, bus.instr_src_3_i, bus.instr_src_2_i, bus.instr_src_1_i} = s;
    {bus.instr_dst_2_i, bus.instr_dst_1_i} = t;
    if (acc_wr) begin
      wb_en = 1'b1;
      wr_a1 = acc_wa;
      wr_d1 = acc_wd;
      wr_a2 = acc_wa + 5'd1;
      wr_d2 = 8'($urandom_range(1, 255));
      ref_mem[wr_a1] = wr_d1;
      ref_mem[wr_a2] = wr_d2;
    end else begin
      wb_en = 1'b0;
    end
    tick();
    bus.instr_valid_i = 1'b0;
    {bus.instr_src_4_i, bus.instr_src_3_i, bus.instr_src_2_i, bus.instr_src_1_i} = 20'($urandom);
    {bus.instr_dst_2_i, bus.instr_dst_1_i} = 10'($urandom);
    last_src = s;
    check_addrs("addr_latch", s);
    check("busy_ready", bus.instr_ready_o, 1'b0);
    for (int k = 0; k < n_coll; k++) begin
      check("coll_valid", bus.op_valid_o, 1'b0);
      drive_wb(1'b1);
      tick();
      exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
      check("retry_step", retry_cnt, exp_retry);
    end
    for (int i = 0; i < 4; i++) exp_d[i] = ref_mem[s[i]];
    check("read_valid", bus.op_valid_o, 1'b0);
    drive_wb(1'b0);
    tick();
    check("wait_valid", bus.op_valid_o, 1'b0);
    drive_wb(1'($urandom_range(0, 1)));
    if (mode == 1) begin
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      drive_wb(1'b0);
      check("flw_valid", bus.op_valid_o, 1'b0);
      check("flw_ready", bus.instr_ready_o, 1'b1);
      check_bundle("flw_old", last_data, last_dst);
      tick();
      check("flw_valid2", bus.op_valid_o, 1'b0);
      return;
    end
    tick();
    if (mode == 3) begin
      check("pre_rst_valid", bus.op_valid_o, 1'b1);
      #2 rst_i = 1'b0;
      drive_wb(1'b0);
      #1;
      check("arst_valid", bus.op_valid_o, 1'b0);
      check("arst_ready", bus.instr_ready_o, 1'b1);
      check("arst_retry", retry_cnt, 0);
      check_addrs("arst", '0);
      check_bundle("arst", '0, '0);
      #3 rst_i = 1'b1;
      clear_ref();
      tick();
      return;
    end
    for (int c = 0; c < stall; c++) begin
      check("stall_valid", bus.op_valid_o, 1'b1);
      check("stall_ready", bus.instr_ready_o, 1'b0);
      check_bundle("stall", exp_d, t);
      drive_wb(1'($urandom_range(0, 1)));
      tick();
    end
    check("hs_valid", bus.op_valid_o, 1'b1);
    check_bundle("hs", exp_d, t);
    if (acc_wr && (s[0] == acc_wa)) check("raw_d1", bus.op_data_1_o, acc_wd);
    if (n_coll > 0) check("nonzero_d1", bus.op_data_1_o != 8'h00, 1'b1);
    bus.op_ready_i = 1'b1;
    if (mode == 2) flush_i = 1'b1;
    drive_wb(1'($urandom_range(0, 1)));
    hs_before = hs_cnt;
    tick();
    bus.op_ready_i = 1'b0;
    flush_i = 1'b0;
    drive_wb(1'b0);
    check("post_valid", bus.op_valid_o, 1'b0);
    check("post_ready", bus.instr_ready_o, 1'b1);
    check("hs_once", hs_cnt - hs_before, 1);
    check("retry_txn", retry_cnt, exp_retry);
    last_data = exp_d;
    last_dst  = t;
  endtask

  initial begin
    logic [3:0][4:0] s;
    logic [1:0][4:0] t;
    rst_i = 1'b0;
    flush_i = 1'b0;
    wb_en = 1'b0;
    wr_a1 = '0; wr_a2 = '0; wr_d1 = '0; wr_d2 = '0;
    bus.instr_valid_i = 1'b0;
    bus.op_ready_i = 1'b0;
    {bus.instr_src_4_i, bus.instr_src_3_i, bus.instr_src_2_i, bus.instr_src_1_i} = '0;
    {bus.instr_dst_2_i, bus.instr_dst_1_i} = '0;
    clear_ref();
    tick();
    tick();
    check("rst_ready", bus.instr_ready_o, 1'b1);
    check("rst_valid", bus.op_valid_o, 1'b0);
    check("rst_retry", retry_cnt, 0);
    check_addrs("rst", '0);
    check_bundle("rst", '0, '0);
    @(negedge clk_i) rst_i = 1'b1;
    tick();

    // Preload the whole file with nonzero data, then the directed values.
    for (int k = 0; k < 16; k++) begin
      wb_en = 1'b1;
      wr_a1 = 5'(2 * k);
      wr_a2 = 5'(2 * k + 1);
      wr_d1 = 8'($urandom_range(1, 255));
      wr_d2 = 8'($urandom_range(1, 255));
      ref_mem[wr_a1] = wr_d1;
      ref_mem[wr_a2] = wr_d2;
      tick();
    end
    wb_en = 1'b1; wr_a1 = 5'd3; wr_d1 = 8'h5A; wr_a2 = 5'd7;  wr_d2 = 8'h11; tick();
    wb_en = 1'b1; wr_a1 = 5'd9; wr_d1 = 8'hF0; wr_a2 = 5'd31; wr_d2 = 8'h80; tick();
    ref_mem[3] = 8'h5A; ref_mem[7] = 8'h11; ref_mem[9] = 8'hF0; ref_mem[31] = 8'h80;
    wb_en = 1'b0;
    tick();

    s = {5'd31, 5'd9, 5'd7, 5'd3};
    t = {5'd2, 5'd1};
    do_txn(s, t, 0, 0, 0, 1'b0, '0, '0);
    check("dir_d1", last_data[0], 8'h5A);
    check("dir_d4", last_data[3], 8'h80);
    do_txn(s, t, 2, 0, 0, 1'b0, '0, '0);
    check("coll2_retry", retry_cnt, 2);
    do_txn({5'd5, 5'd6, 5'd7, 5'd8}, {5'd9, 5'd10}, 0, 5, 0, 1'b0, '0, '0);
    do_txn({5'd12, 5'd11, 5'd10, 5'd4}, {5'd3, 5'd4}, 0, 0, 0, 1'b1, 5'd4, 8'h33);
    do_txn({5'd1, 5'd2, 5'd3, 5'd4}, {5'd5, 5'd6}, 1, 0, 1, 1'b0, '0, '0);
    do_txn({5'd20, 5'd21, 5'd22, 5'd23}, {5'd7, 5'd8}, 0, 1, 2, 1'b0, '0, '0);
    do_txn({5'd0, 5'd15, 5'd16, 5'd30}, {5'd11, 5'd12}, 300, 0, 0, 1'b0, '0, '0);
    check("sat_retry", retry_cnt, 8'hFF);

    for (int n = 0; n < 20; n++) begin
      s = 20'($urandom);
      if (n % 4 == 0) s[1] = s[0];
      t = 10'($urandom);
      do_txn(s, t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 1'b0, '0, '0);
    end

    do_txn({5'd3, 5'd3, 5'd9, 5'd9}, {5'd13, 5'd14}, 1, 2, 3, 1'b0, '0, '0);
    do_txn({5'd17, 5'd18, 5'd19, 5'd3}, {5'd15, 5'd16}, 1, 1, 0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
